// File: rtl/zorro3_autoconfig_chain_pkg.sv
// Package zorro_ac_pkg: autoconfig register offsets, per-board state
// encoding, Zorro III extended size codes and the size-mask helper.
package zorro_ac_pkg;

    // Config-space register offsets (off = {A7..A2, A8, 0})
    localparam logic [7:0] AC_OFF_ERTYPE  = 8'h00;
    localparam logic [7:0] AC_OFF_ERSIZE  = 8'h02;
    localparam logic [7:0] AC_OFF_PROD_HI = 8'h04;
    localparam logic [7:0] AC_OFF_PROD_LO = 8'h06;
    localparam logic [7:0] AC_OFF_FLAGS   = 8'h08;
    localparam logic [7:0] AC_OFF_RSVD    = 8'h0A;
    localparam logic [7:0] AC_OFF_MFG     = 8'h10;
    localparam logic [7:0] AC_OFF_SERIAL  = 8'h18;
    localparam logic [7:0] AC_OFF_ROMVEC  = 8'h28;
    localparam logic [7:0] AC_OFF_BASE    = 8'h44;
    localparam logic [7:0] AC_OFF_SHUTUP  = 8'h4C;

    // A31..A24 value that selects autoconfig space
    localparam logic [7:0] AC_CFG_SPACE   = 8'hFF;

    // Zorro III extended size codes
    localparam logic [2:0] AC_SIZE_16M    = 3'd0;
    localparam logic [2:0] AC_SIZE_32M    = 3'd1;
    localparam logic [2:0] AC_SIZE_64M    = 3'd2;
    localparam logic [2:0] AC_SIZE_128M   = 3'd3;

    typedef enum logic [1:0] {
        AC_UNCFG = 2'd0,
        AC_CFG   = 2'd1,
        AC_SHUT  = 2'd2
    } ac_state_e;

    // A31..A24 compare mask for a board window of the given size code
    function automatic logic [7:0] ac_size_mask(input logic [2:0] code);
        logic [7:0] m;
        case (code)
            AC_SIZE_16M:  m = 8'hFF;
            AC_SIZE_32M:  m = 8'hFE;
            AC_SIZE_64M:  m = 8'hFC;
            AC_SIZE_128M: m = 8'hF8;
            default:      m = 8'hFF;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/zorro3_autoconfig_chain_if.sv
// Zorro bus-glue <-> autoconfig engine signal bundle.
// master: bus glue side, slave: autoconfig engine side.
interface zorro3_autoconfig_chain_if #(
    parameter int N_BOARDS = 2
) ();
    logic                Z_FCS_n;
    logic                DOE;
    logic                DS3_n;
    logic [1:0]          FC;
    logic                READ;
    logic [7:0]          DIN;
    logic [7:0]          addrh;
    logic [8:2]          addrl;
    logic                BERR_n;
    logic                SENSEZ3;
    logic                CFGIN_n;
    logic [3:0]          data_out;
    logic                config_cycle;
    logic [N_BOARDS-1:0] card_cycle;
    logic                dtack;

    modport master (
        output Z_FCS_n, DOE, DS3_n, FC, READ, DIN, addrh, addrl, BERR_n, SENSEZ3, CFGIN_n,
        input  data_out, config_cycle, card_cycle, dtack
    );

    modport slave (
        input  Z_FCS_n, DOE, DS3_n, FC, READ, DIN, addrh, addrl, BERR_n, SENSEZ3, CFGIN_n,
        output data_out, config_cycle, card_cycle, dtack
    );
endinterface

// File: rtl/zorro3_autoconfig_chain_rom.sv
// zorro_ac_rom: combinational autoconfig ROM nibble lookup for one board.
// Output is the bus value: inverted except for offsets 00 and 02.
module zorro_ac_rom
    import zorro_ac_pkg::*;
(
    input  logic [7:0]  off,
    input  logic [7:0]  prod_id,
    input  logic [15:0] mfg_id,
    input  logic [31:0] serial,
    input  logic [15:0] romvec,
    input  logic        chain,
    input  logic [2:0]  size,
    output logic [3:0]  data_out
);
    logic [3:0] true_s;

    // True ROM nibble, then bus polarity
    always_comb begin
        true_s = 4'hF;
        case (off)
            AC_OFF_ERTYPE:          true_s = {2'b10, 1'b0, (romvec != 16'h0000)};
            AC_OFF_ERSIZE:          true_s = {chain, size};
            AC_OFF_PROD_HI:         true_s = prod_id[7:4];
            AC_OFF_PROD_LO:         true_s = prod_id[3:0];
            AC_OFF_FLAGS:           true_s = 4'b0011;
            AC_OFF_RSVD:            true_s = 4'h0;
            AC_OFF_MFG:             true_s = mfg_id[15:12];
            AC_OFF_MFG + 8'h02:     true_s = mfg_id[11:8];
            AC_OFF_MFG + 8'h04:     true_s = mfg_id[7:4];
            AC_OFF_MFG + 8'h06:     true_s = mfg_id[3:0];
            AC_OFF_SERIAL:          true_s = serial[31:28];
            AC_OFF_SERIAL + 8'h02:  true_s = serial[27:24];
            AC_OFF_SERIAL + 8'h04:  true_s = serial[23:20];
            AC_OFF_SERIAL + 8'h06:  true_s = serial[19:16];
            AC_OFF_SERIAL + 8'h08:  true_s = serial[15:12];
            AC_OFF_SERIAL + 8'h0A:  true_s = serial[11:8];
            AC_OFF_SERIAL + 8'h0C:  true_s = serial[7:4];
            AC_OFF_SERIAL + 8'h0E:  true_s = serial[3:0];
            AC_OFF_ROMVEC:          true_s = romvec[15:12];
            AC_OFF_ROMVEC + 8'h02:  true_s = romvec[11:8];
            AC_OFF_ROMVEC + 8'h04:  true_s = romvec[7:4];
            AC_OFF_ROMVEC + 8'h06:  true_s = romvec[3:0];
            default:                true_s = 4'hF;
        endcase
        if (off == AC_OFF_ERTYPE || off == AC_OFF_ERSIZE) begin
            data_out = true_s;
        end else begin
            data_out = ~true_s;
        end
    end
endmodule

// File: rtl/zorro3_autoconfig_chain.sv
// zorro3_autoconfig_chain: Zorro III autoconfig engine for N_BOARDS logical
// boards in one chain, plus post-configuration window decode.
// Optional build macro: AC_BOARD_ENABLE_EN adds the board_en port.
module zorro3_autoconfig_chain
    import zorro_ac_pkg::*;
#(
    parameter int                    N_BOARDS = 2,
    parameter logic [3*N_BOARDS-1:0] SIZE_EXT = {(3*N_BOARDS){1'b0}}
) (
    input  logic                     clk,
    input  logic                     reset,
    zorro3_autoconfig_chain_if.slave bus,
    input  logic [15:0]              mfg_id,
    input  logic [8*N_BOARDS-1:0]    prod_id,
    input  logic [31:0]              serial,
    input  logic [16*N_BOARDS-1:0]   romvec,
`ifdef AC_BOARD_ENABLE_EN
    input  logic [N_BOARDS-1:0]      board_en,
`endif
    output logic                     cfgout,
    output logic [8*N_BOARDS-1:0]    base_addr,
    output logic [N_BOARDS-1:0]      configured
);
    localparam int               IDX_W    = 3;
    localparam logic [IDX_W-1:0] IDX_DONE = IDX_W'(N_BOARDS);

    ac_state_e           state_r [N_BOARDS];
    logic [7:0]          base_r  [N_BOARDS];
    logic [N_BOARDS-1:0] configured_r;
    logic [N_BOARDS-1:0] card_r;
    logic                config_r;
    logic                dtack_r;
    logic                wr_seen_r;
    logic                fcs_q_r;
    logic                cfgout_r;

    logic [N_BOARDS-1:0] en_s;
    logic [N_BOARDS-1:0] hit_s;
    logic [N_BOARDS-1:0] pick_s;
    logic                pick_any_s;
    logic [IDX_W-1:0]    idx_s;
    logic [IDX_W-1:0]    last_s;
    logic [IDX_W-1:0]    sel_s;
    logic                done_s;
    logic                chain_s;
    logic                cycle_end_s;
    logic                cfg_hit_s;
    logic                qual_s;
    logic                commit_s;
    logic [7:0]          off_s;
    logic [7:0]          prod_sel_s;
    logic [15:0]         romvec_sel_s;
    logic [2:0]          size_sel_s;
    logic [3:0]          rom_nib_s;

`ifdef AC_BOARD_ENABLE_EN
    assign en_s = board_en;
`else
    assign en_s = {N_BOARDS{1'b1}};
`endif

    assign cycle_end_s = bus.Z_FCS_n | ~bus.BERR_n | (bus.FC[1] == bus.FC[0])
                       | bus.CFGIN_n | ~bus.SENSEZ3;
    assign off_s       = {bus.addrl[7:2], bus.addrl[8], 1'b0};

    // Current board: lowest enabled board still unconfigured
    always_comb begin
        idx_s = IDX_DONE;
        for (int i = N_BOARDS - 1; i >= 0; i--) begin
            idx_s = (state_r[i] == AC_UNCFG && en_s[i]) ? IDX_W'(i) : idx_s;
        end
    end

    // Last enabled board: the one that reports no further chain entry
    always_comb begin
        last_s = {IDX_W{1'b0}};
        for (int i = 0; i < N_BOARDS; i++) begin
            last_s = en_s[i] ? IDX_W'(i) : last_s;
        end
    end

    assign done_s    = (idx_s == IDX_DONE);
    assign chain_s   = (idx_s != last_s);
    assign sel_s     = done_s ? {IDX_W{1'b0}} : idx_s;
    assign cfg_hit_s = ~done_s & (bus.addrh == AC_CFG_SPACE);
    assign qual_s    = config_r & bus.DOE & ~bus.DS3_n;
    assign commit_s  = ~cycle_end_s & qual_s & ~wr_seen_r & ~bus.READ & ~done_s;

    // Per-board ROM fields for the board currently presented
    always_comb begin
        prod_sel_s   = 8'h00;
        romvec_sel_s = 16'h0000;
        size_sel_s   = 3'b000;
        for (int i = 0; i < N_BOARDS; i++) begin
            prod_sel_s   = (sel_s == IDX_W'(i)) ? prod_id[8*i +: 8]   : prod_sel_s;
            romvec_sel_s = (sel_s == IDX_W'(i)) ? romvec[16*i +: 16]  : romvec_sel_s;
            size_sel_s   = (sel_s == IDX_W'(i)) ? SIZE_EXT[3*i +: 3]  : size_sel_s;
        end
    end

    zorro_ac_rom u_rom (
        .off      (off_s),
        .prod_id  (prod_sel_s),
        .mfg_id   (mfg_id),
        .serial   (serial),
        .romvec   (romvec_sel_s),
        .chain    (chain_s),
        .size     (size_sel_s),
        .data_out (rom_nib_s)
    );

    // Window decode of configured boards; lowest board wins on overlap
    always_comb begin
        hit_s      = {N_BOARDS{1'b0}};
        pick_s     = {N_BOARDS{1'b0}};
        pick_any_s = 1'b0;
        for (int i = 0; i < N_BOARDS; i++) begin
            hit_s[i]   = (state_r[i] == AC_CFG) &&
                         ((bus.addrh & ac_size_mask(SIZE_EXT[3*i +: 3])) ==
                          (base_r[i] & ac_size_mask(SIZE_EXT[3*i +: 3])));
            pick_s[i]  = hit_s[i] & ~pick_any_s;
            pick_any_s = pick_any_s | hit_s[i];
        end
    end

    // Bus-cycle tracking: config/card hits, acknowledge, one-shot write guard
    always_ff @(posedge clk) begin
        if (reset) begin
            config_r  <= 1'b0;
            card_r    <= {N_BOARDS{1'b0}};
            dtack_r   <= 1'b0;
            wr_seen_r <= 1'b0;
        end else if (cycle_end_s) begin
            config_r  <= 1'b0;
            card_r    <= {N_BOARDS{1'b0}};
            dtack_r   <= 1'b0;
            wr_seen_r <= 1'b0;
        end else begin
            config_r  <= config_r | cfg_hit_s;
            card_r    <= card_r | (pick_s & {N_BOARDS{~cfg_hit_s & ~config_r}});
            dtack_r   <= dtack_r | qual_s;
            wr_seen_r <= wr_seen_r | qual_s;
        end
    end

    // Per-board configuration state, base address commit and skip of disabled boards
    always_ff @(posedge clk) begin
        if (reset) begin
            configured_r <= {N_BOARDS{1'b0}};
            for (int i = 0; i < N_BOARDS; i++) begin
                state_r[i] <= AC_UNCFG;
                base_r[i]  <= 8'hFF;
            end
        end else begin
            for (int i = 0; i < N_BOARDS; i++) begin
                if (commit_s && idx_s == IDX_W'(i)) begin
                    if (off_s == AC_OFF_BASE) begin
                        state_r[i]      <= AC_CFG;
                        base_r[i]       <= bus.DIN;
                        configured_r[i] <= 1'b1;
                    end else if (off_s == AC_OFF_SHUTUP) begin
                        state_r[i] <= AC_SHUT;
                    end else begin
                        state_r[i] <= state_r[i];
                    end
                end else if (state_r[i] == AC_UNCFG && !en_s[i]) begin
                    state_r[i] <= AC_SHUT;
                end else begin
                    state_r[i] <= state_r[i];
                end
            end
        end
    end

    // CFGOUT: raised at the end of a bus cycle (FCS rising edge) once the chain is done
    always_ff @(posedge clk) begin
        if (reset) begin
            fcs_q_r  <= 1'b1;
            cfgout_r <= 1'b0;
        end else begin
            fcs_q_r  <= bus.Z_FCS_n;
            cfgout_r <= cfgout_r | (bus.Z_FCS_n & ~fcs_q_r & done_s);
        end
    end

    // Pack per-board base addresses onto the output vector
    always_comb begin
        base_addr = {(8*N_BOARDS){1'b0}};
        for (int i = 0; i < N_BOARDS; i++) begin
            base_addr[8*i +: 8] = base_r[i];
        end
    end

    assign bus.data_out     = (reset | done_s) ? 4'hF : rom_nib_s;
    assign bus.config_cycle = config_r;
    assign bus.card_cycle   = card_r;
    assign bus.dtack        = dtack_r;
    assign cfgout           = cfgout_r;
    assign configured       = configured_r;
endmodule

// File: tb/tb_zorro3_autoconfig_chain.sv
// Self-checking bench for zorro3_autoconfig_chain (N_BOARDS=2).
// Random ids/bases/hold lengths checked against a transaction-level chain model.
module tb_zorro3_autoconfig_chain;
    localparam int N = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] mfg_id;
    logic [15:0] prod_id;
    logic [31:0] serial;
    logic [31:0] romvec;
    logic [1:0]  board_en;
    logic        cfgout;
    logic [15:0] base_addr;
    logic [1:0]  configured;
    logic [5:0]  sz_v;

    int          n_checks = 0;
    int          n_fail = 0;
    int          st [N];
    logic [7:0]  mb [N];
    logic        cfgm;
    logic [7:0]  offs [22];

    always #5 clk = ~clk;

    zorro3_autoconfig_chain_if #(.N_BOARDS(N)) bus ();

    zorro3_autoconfig_chain #(.N_BOARDS(N), .SIZE_EXT(6'b010_001)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .mfg_id     (mfg_id),
        .prod_id    (prod_id),
        .serial     (serial),
        .romvec     (romvec),
`ifdef AC_BOARD_ENABLE_EN
        .board_en   (board_en),
`endif
        .cfgout     (cfgout),
        .base_addr  (base_addr),
        .configured (configured)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int m_idx();
        for (int b = 0; b < N; b++) if (st[b] == 0 && board_en[b]) return b;
        return N;
    endfunction

    function automatic int m_last();
        int l = 0;
        for (int b = 0; b < N; b++) if (board_en[b]) l = b;
        return l;
    endfunction

    function automatic logic [3:0] m_rom(input int b, input logic [7:0] off);
        logic [3:0]  t;
        logic [15:0] rv;
        int          k;
        rv = romvec[16*b +: 16];
        k  = int'(off);
        if (k == 0)                   t = {2'b10, 1'b0, (rv != 16'h0)};
        else if (k == 2)              t = {(b != m_last()), sz_v[3*b +: 3]};
        else if (k == 4 || k == 6)    t = 4'(prod_id[8*b +: 8] >> ((k == 4) ? 4 : 0));
        else if (k == 8)              t = 4'b0011;
        else if (k == 10)             t = 4'h0;
        else if (k >= 16 && k <= 22)  t = 4'(mfg_id >> (4 * (3 - (k - 16) / 2)));
        else if (k >= 24 && k <= 38)  t = 4'(serial >> (4 * (7 - (k - 24) / 2)));
        else if (k >= 40 && k <= 46)  t = 4'(rv >> (4 * (3 - (k - 40) / 2)));
        else                          t = 4'hF;
        return (k == 0 || k == 2) ? t : ~t;
    endfunction

    function automatic logic [1:0] m_card(input logic [7:0] ah);
        logic [1:0] r = 2'b00;
        int         k;
        for (int b = 0; b < N; b++) begin
            k = int'(sz_v[3*b +: 3]);
            if (st[b] == 1 && (ah >> k) == (mb[b] >> k) && r == 2'b00) r[b] = 1'b1;
        end
        return r;
    endfunction

    task automatic m_init();
        for (int b = 0; b < N; b++) begin
            st[b] = 0;
            mb[b] = 8'hFF;
        end
        cfgm = 1'b0;
    endtask

    task automatic idle();
        bus.Z_FCS_n = 1'b1; bus.DOE = 1'b0; bus.DS3_n = 1'b1; bus.FC = 2'b01;
        bus.READ = 1'b1; bus.DIN = 8'h00; bus.BERR_n = 1'b1; bus.SENSEZ3 = 1'b1;
        bus.CFGIN_n = 1'b0;
    endtask

    task automatic set_addr(input logic [7:0] ah, input logic [7:0] off);
        bus.addrh = ah;
        bus.addrl = {off[1], off[7:2]};
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_configured"}, 32'(configured), 32'({st[1] == 1, st[0] == 1}));
        chk({tag, "_base"}, 32'(base_addr), 32'({mb[1], mb[0]}));
        chk({tag, "_cfgout"}, 32'(cfgout), 32'(cfgm));
    endtask

    task automatic chk_reset_vals();
        chk("rst_data_out", 32'(bus.data_out), 32'h0000_000F);
        chk("rst_config_cycle", 32'(bus.config_cycle), 32'h0);
        chk("rst_card_cycle", 32'(bus.card_cycle), 32'h0);
        chk("rst_dtack", 32'(bus.dtack), 32'h0);
        chk("rst_cfgout", 32'(cfgout), 32'h0);
        chk("rst_base", 32'(base_addr), 32'h0000_FFFF);
        chk("rst_configured", 32'(configured), 32'h0);
    endtask

    task automatic do_reset();
        idle();
        set_addr(8'h00, 8'h00);
        reset = 1'b1;
        step();
        step();
        chk_reset_vals();
        reset = 1'b0;
        m_init();
        step();
    endtask

    // One complete Zorro III cycle; DS3_n/DOE held 'hold' clocks
    task automatic acc(input logic [7:0] ah, input logic [7:0] off, input logic rd,
                       input logic [7:0] din, input int hold);
        int         ci;
        logic       ecfg;
        logic [1:0] ecard;
        logic [3:0] edata;
        ci    = m_idx();
        ecfg  = (ah == 8'hFF) && (ci != N);
        ecard = ecfg ? 2'b00 : m_card(ah);
        edata = (ci == N) ? 4'hF : m_rom(ci, off);
        set_addr(ah, off);
        bus.READ = rd;
        bus.DIN = din;
        bus.Z_FCS_n = 1'b0;
        step();
        chk("config_cycle", 32'(bus.config_cycle), 32'(ecfg));
        chk("card_cycle", 32'(bus.card_cycle), 32'(ecard));
        bus.DOE = 1'b1;
        bus.DS3_n = 1'b0;
        #1;
        chk("data_out", 32'(bus.data_out), 32'(edata));
        for (int h = 0; h < hold; h++) begin
            step();
            chk("dtack", 32'(bus.dtack), 32'(ecfg));
            chk("cfgout_mid", 32'(cfgout), 32'(cfgm));
        end
        if (ecfg && !rd) begin
            if (off == 8'h44) begin
                st[ci] = 1;
                mb[ci] = din;
            end else if (off == 8'h4C) begin
                st[ci] = 2;
            end
        end
        chk_state("commit");
        idle();
        step();
        if (m_idx() == N) cfgm = 1'b1;
        chk("end_config_cycle", 32'(bus.config_cycle), 32'h0);
        chk("end_dtack", 32'(bus.dtack), 32'h0);
        chk("end_card_cycle", 32'(bus.card_cycle), 32'h0);
        chk("end_cfgout", 32'(cfgout), 32'(cfgm));
    endtask

    initial begin
        int         k;
        int         guard;
        int         b;
        logic [7:0] base;
        logic [7:0] ah;
        logic [7:0] msk;

        sz_v = 6'b010_001;
        k = 0;
        for (int i = 0; i < 6; i++) begin offs[k] = 8'(2 * i); k++; end
        for (int i = 0; i < 16; i++) begin offs[k] = 8'(16 + 2 * i); k++; end
        mfg_id = 16'h0; prod_id = 16'h0; serial = 32'h0; romvec = 32'h0;
        board_en = 2'b11;
        idle();
        set_addr(8'h00, 8'h00);

        for (int r = 0; r < 8; r++) begin
            mfg_id  = 16'($urandom);
            prod_id = 16'($urandom);
            serial  = $urandom;
            romvec  = {($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'h0000,
                       ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'h0000};
`ifdef AC_BOARD_ENABLE_EN
            board_en = (r == 0) ? 2'b01 : 2'($urandom);
`else
            board_en = 2'b11;
`endif
            do_reset();

            if (r == 0) begin
                // Board0 ROM, base 40; board1 ROM, base 80; then window decode
                acc(8'hFF, 8'h00, 1'b1, 8'h00, 1);
                acc(8'hFF, 8'h02, 1'b1, 8'h00, 1);
                acc(8'hFF, 8'h44, 1'b0, 8'h40, 1);
                acc(8'hFF, 8'h02, 1'b1, 8'h00, 1);
                acc(8'hFF, 8'h44, 1'b0, 8'h80, 1);
                acc(8'h41, 8'h00, 1'b1, 8'h00, 1);
                acc(8'h42, 8'h00, 1'b1, 8'h00, 1);
                acc(8'h83, 8'h00, 1'b1, 8'h00, 1);
                acc(8'h84, 8'h00, 1'b1, 8'h00, 1);
            end else if (r == 1) begin
                // Bus error mid-cycle drops config_cycle and dtack next clock
                set_addr(8'hFF, 8'h00);
                bus.READ = 1'b1;
                bus.Z_FCS_n = 1'b0;
                step();
                chk("berr_cfg_pre", 32'(bus.config_cycle), 32'(m_idx() != N));
                bus.DOE = 1'b1;
                bus.DS3_n = 1'b0;
                step();
                chk("berr_dtack_pre", 32'(bus.dtack), 32'(m_idx() != N));
                bus.BERR_n = 1'b0;
                step();
                chk("berr_cfg", 32'(bus.config_cycle), 32'h0);
                chk("berr_dtack", 32'(bus.dtack), 32'h0);
                idle();
                step();
                if (m_idx() == N) cfgm = 1'b1;
                chk_state("berr");
            end else if (r == 2) begin
                // Shut up board0, then reset lands on board1's committing clock
                acc(8'hFF, 8'h4C, 1'b0, 8'h00, 2);
                set_addr(8'hFF, 8'h44);
                bus.READ = 1'b0;
                bus.DIN = 8'h55;
                bus.Z_FCS_n = 1'b0;
                step();
                bus.DOE = 1'b1;
                bus.DS3_n = 1'b0;
                reset = 1'b1;
                step();
                chk_reset_vals();
                reset = 1'b0;
                idle();
                m_init();
                step();
                acc(8'hFF, 8'h00, 1'b1, 8'h00, 1);
            end

            guard = 0;
            while (m_idx() != N && guard < 8) begin
                guard++;
                for (int j = 0; j < 2; j++)
                    acc(8'hFF, offs[$urandom_range(0, 21)], 1'b1, 8'h00, 1);
                acc(8'($urandom_range(0, 254)), 8'h00, 1'b1, 8'h00, 1);
                if ($urandom_range(0, 2) == 0)
                    acc(8'hFF, 8'h48, 1'b0, 8'($urandom), 1);
                b = m_idx();
                base = (b == 0) ? {1'b0, 7'($urandom)} : 8'($urandom_range(128, 247));
                if ($urandom_range(0, 4) == 0)
                    acc(8'hFF, 8'h4C, 1'b0, base, $urandom_range(1, 5));
                else
                    acc(8'hFF, 8'h44, 1'b0, base, $urandom_range(1, 5));
            end

            for (int bb = 0; bb < N; bb++) begin
                if (st[bb] == 1) begin
                    msk = ~(8'hFF << sz_v[3*bb +: 3]);
                    ah = mb[bb] ^ (8'($urandom) & msk);
                    acc(ah, 8'h00, 1'b1, 8'h00, 1);
                end
            end
            for (int j = 0; j < 3; j++)
                acc(8'($urandom), offs[$urandom_range(0, 21)], 1'b1, 8'h00, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
